hex_encode: RTL and testbench

//   Converts a 4-bit binary nibble into an 8-bit seven-segment display pattern
//   for hex digits 0-9 and A-F.

---
 rtl/hex_encode.sv | 67 ++++++
 tb/tb_hex_encode.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/hex_encode.sv
// hex_encode: 4-bit nibble to seven-segment pattern {dp,g,f,e,d,c,b,a}.
// Optional output register enabled by defining HEX_ENCODE_OUTREG_EN;
// without it the decode is purely combinational and clk/rst_n are unused.
module hex_encode #(
  parameter bit ACTIVE_LOW = 1'b1,  // 1: segment lit when bit is 0
  parameter bit NINE_TAIL  = 1'b1   // 1: digit 9 drawn with segment d
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] bin,
  output logic [7:0] hex
);

  // Blank display: every segment and the dp off, in the selected polarity.
  localparam logic [7:0] BLANK = ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [6:0] lit;    // active-high lit mask {g,f,e,d,c,b,a}
  logic [7:0] hex_d;

  // Full 16-entry glyph table, active-high; every code has an entry.
  always_comb begin
    lit = 7'h00;
    case (bin)
      4'h0: lit = 7'h3F;
      4'h1: lit = 7'h06;
      4'h2: lit = 7'h5B;
      4'h3: lit = 7'h4F;
      4'h4: lit = 7'h66;
      4'h5: lit = 7'h6D;
      4'h6: lit = 7'h7D;
      4'h7: lit = 7'h07;
      4'h8: lit = 7'h7F;
      4'h9: lit = NINE_TAIL ? 7'h6F : 7'h67;
      4'hA: lit = 7'h77;
      4'hB: lit = 7'h7C;
      4'hC: lit = 7'h39;
      4'hD: lit = 7'h5E;
      4'hE: lit = 7'h79;
      4'hF: lit = 7'h71;
      default: lit = 7'bxxxxxxx;  // only reachable with X/Z on bin
    endcase
  end

  // Apply output polarity; dp is always off.
  always_comb begin
    hex_d = ACTIVE_LOW ? {1'b1, ~lit} : {1'b0, lit};
  end

`ifdef HEX_ENCODE_OUTREG_EN
  logic [7:0] hex_q;

  // Output register; reset blanks the display immediately, clock or not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hex_q <= BLANK;
    else        hex_q <= hex_d;
  end

  assign hex = hex_q;
`else
  // Clock and reset are deliberately unused in the combinational build.
  logic unused_clk_rst;
  assign unused_clk_rst = &{1'b0, clk, rst_n, BLANK};

  assign hex = hex_d;
`endif

endmodule

// File: tb/tb_hex_encode.sv
// Bench for hex_encode: three parameter variants driven in parallel with
// directed and random nibbles, compared against a segment-name glyph model.
// Covers both builds (HEX_ENCODE_OUTREG_EN defined or not).
module tb_hex_encode;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] bin;
  logic [7:0] hex_def, hex_nt0, hex_ah;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  hex_encode #(.ACTIVE_LOW(1'b1), .NINE_TAIL(1'b1)) u_def (
    .clk(clk), .rst_n(rst_n), .bin(bin), .hex(hex_def));
  hex_encode #(.ACTIVE_LOW(1'b1), .NINE_TAIL(1'b0)) u_nt0 (
    .clk(clk), .rst_n(rst_n), .bin(bin), .hex(hex_nt0));
  hex_encode #(.ACTIVE_LOW(1'b0), .NINE_TAIL(1'b1)) u_ah (
    .clk(clk), .rst_n(rst_n), .bin(bin), .hex(hex_ah));

  // Glyphs described by the names of the segments that light up.
  function automatic string glyph(input int d, input bit nine_tail);
    string g[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                     "acdefg", "abc", "abcdefg", "abcdfg", "abcefg", "cdefg",
                     "adef", "bcdeg", "adefg", "aefg"};
    if (d == 9 && !nine_tail) return "abcfg";
    return g[d];
  endfunction

  function automatic logic [7:0] model(input int d, input bit active_low,
                                       input bit nine_tail);
    string s;
    logic [7:0] on;
    s = glyph(d, nine_tail);
    on = 8'h00;
    for (int i = 0; i < s.len(); i++) on[s[i] - "a"] = 1'b1;
    return active_low ? ~on : on;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int d);
    check({tag, " def"}, hex_def, model(d, 1'b1, 1'b1));
    check({tag, " nt0"}, hex_nt0, model(d, 1'b1, 1'b0));
    check({tag, " ah"},  hex_ah,  model(d, 1'b0, 1'b1));
  endtask

  task automatic check_blank(input string tag);
    check({tag, " def"}, hex_def, 8'hFF);
    check({tag, " nt0"}, hex_nt0, 8'hFF);
    check({tag, " ah"},  hex_ah,  8'h00);
  endtask

  // Drive a nibble mid-cycle and sample once it should be visible.
  task automatic apply(input int d);
    @(negedge clk);
    bin = d[3:0];
`ifdef HEX_ENCODE_OUTREG_EN
    @(posedge clk);
`endif
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bin   = 4'h0;
    #2;
`ifdef HEX_ENCODE_OUTREG_EN
    check_blank("reset no clock");
    @(negedge clk);
    bin = 4'h3;
    rst_n = 1'b1;
    #1;
    check_blank("released before edge");
    @(posedge clk);
    #1;
    check("first after reset", hex_def, 8'hB0);
`else
    rst_n = 1'b1;
`endif

    // Exhaustive sweep with fixed table values for the default variant.
    for (int d = 0; d < 16; d++) begin
      logic [7:0] tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92,
                               8'h82, 8'hF8, 8'h80, 8'h90, 8'h88, 8'h83,
                               8'hC6, 8'hA1, 8'h86, 8'h8E};
      apply(d);
      check($sformatf("sweep %0d", d), hex_def, tbl[d]);
      check_all($sformatf("sweep %0d", d), d);
      check($sformatf("ah dp %0d", d), {7'h00, hex_ah[7]}, 8'h00);
      check($sformatf("no X %0d", d), {7'h00, $isunknown(hex_def)}, 8'h00);
    end

    apply(9);
    check("nine tail off", hex_nt0, 8'h98);
    check("nine tail on", hex_def, 8'h90);
    apply(0);
    check("ah 0", hex_ah, 8'h3F);
    apply(8);
    check("ah 8", hex_ah, 8'h7F);
    apply(15);
    check("ah F", hex_ah, 8'h71);

    // Random nibbles.
    for (int n = 0; n < 60; n++) begin
      int d;
      d = int'($urandom_range(0, 15));
      apply(d);
      check_all($sformatf("rand %0d", d), d);
    end

`ifdef HEX_ENCODE_OUTREG_EN
    // Value held between edges, then updated on the next posedge.
    apply(1);
    check("hold 1", hex_def, 8'hF9);
    @(negedge clk);
    bin = 4'h2;
    #1;
    check("hold before edge", hex_def, 8'hF9);
    @(posedge clk);
    #1;
    check("after edge", hex_def, 8'hA4);
    // Asynchronous reset mid-stream.
    #2;
    rst_n = 1'b0;
    #1;
    check_blank("mid reset");
    @(posedge clk);
    #1;
    check_blank("reset held over edge");
    rst_n = 1'b1;
    apply(5);
    check_all("after mid reset", 5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
